// File: rtl/fifo_sync_core.sv
// Single-clock FIFO storage and pointer core with registered status flags.
// Sits behind the write-control stage; o_full feeds back as that stage's full input.
module fifo_sync_core #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 3,
   parameter int AFULL_TH = 6
) (
   input  logic              i_clk,
   input  logic              i_rest,
   input  logic              i_wen_ctrl,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_ren,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_rvalid,
   output logic              o_full,
   output logic              o_empty,
   output logic              o_afull,
   output logic [ADDR_W:0]   o_count,
   output logic              o_overflow,
   output logic              o_underflow
);

   localparam int              DEPTH   = 2 ** ADDR_W;
   localparam int              CNT_W   = ADDR_W + 1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_TH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [CNT_W-1:0]  wptr;
   logic [CNT_W-1:0]  rptr;
   logic [CNT_W-1:0]  count_nxt;
   logic              wr_acc;
   logic              rd_acc;

   // Acceptance uses the flags registered before the edge, so a write landing
   // in the cycle o_full rises is dropped and reported through o_overflow.
   always_comb begin
      wr_acc    = i_wen_ctrl & ~o_full;
      rd_acc    = i_ren & ~o_empty;
      count_nxt = o_count;
      if (wr_acc && !rd_acc) begin
         count_nxt = o_count + CNT_ONE;
      end else if (rd_acc && !wr_acc) begin
         count_nxt = o_count - CNT_ONE;
      end
   end

   always_ff @(posedge i_clk) begin
      if (wr_acc && !i_rest) begin
         mem[wptr[ADDR_W-1:0]] <= i_wdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rest) begin
         wptr        <= '0;
         rptr        <= '0;
         o_count     <= '0;
         o_rdata     <= '0;
         o_rvalid    <= 1'b0;
         o_full      <= 1'b0;
         o_empty     <= 1'b1;
         o_afull     <= 1'b0;
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
      end else begin
         if (wr_acc) begin
            wptr <= wptr + CNT_ONE;
         end
         if (rd_acc) begin
            rptr    <= rptr + CNT_ONE;
            o_rdata <= mem[rptr[ADDR_W-1:0]];
         end
         o_rvalid    <= rd_acc;
         o_overflow  <= i_wen_ctrl & o_full;
         o_underflow <= i_ren & o_empty;
         o_count     <= count_nxt;
         // Flags come from the next-state count so they line up with o_count.
         o_full      <= (count_nxt == DEPTH_C);
         o_empty     <= (count_nxt == '0);
         o_afull     <= (count_nxt >= AFULL_C);
      end
   end

endmodule

// File: tb/tb_fifo_sync_core.sv
// Directed bench for fifo_sync_core: expected read data goes into a queue at issue
// time and a negedge monitor pops and compares whenever o_rvalid is seen.
module tb_fifo_sync_core;

   logic       i_clk = 1'b0;
   logic       i_rest;
   logic       i_wen_ctrl;
   logic [7:0] i_wdata;
   logic       i_ren;
   logic [7:0] o_rdata;
   logic       o_rvalid;
   logic       o_full;
   logic       o_empty;
   logic       o_afull;
   logic [3:0] o_count;
   logic       o_overflow;
   logic       o_underflow;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] exp_q [$];
   logic [7:0] mq [$];
   logic [7:0] last_rdata;

   fifo_sync_core dut (
      .i_clk      (i_clk),
      .i_rest     (i_rest),
      .i_wen_ctrl (i_wen_ctrl),
      .i_wdata    (i_wdata),
      .i_ren      (i_ren),
      .o_rdata    (o_rdata),
      .o_rvalid   (o_rvalid),
      .o_full     (o_full),
      .o_empty    (o_empty),
      .o_afull    (o_afull),
      .o_count    (o_count),
      .o_overflow (o_overflow),
      .o_underflow(o_underflow)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every o_rvalid must match the oldest outstanding expected word.
   always @(negedge i_clk) begin
      if (o_rvalid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("rvalid_unexpected", 1, 0);
         end else begin
            check("rdata", int'(o_rdata), int'(exp_q.pop_front()));
         end
      end
   end

   // One clock of stimulus; the bench model decides acceptance from pre-edge state.
   task automatic step(input logic rst, input logic w, input logic [7:0] d, input logic r);
      logic full_pre, empty_pre, er, eo, eu;
      full_pre  = (mq.size() == 8);
      empty_pre = (mq.size() == 0);
      i_rest = rst; i_wen_ctrl = w; i_wdata = d; i_ren = r;
      if (rst) begin
         mq.delete();
         last_rdata = 8'h00;
         er = 1'b0; eo = 1'b0; eu = 1'b0;
      end else begin
         er = r && !empty_pre;
         eo = w && full_pre;
         eu = r && empty_pre;
         if (er) begin
            last_rdata = mq.pop_front();
            exp_q.push_back(last_rdata);
         end
         if (w && !full_pre) mq.push_back(d);
      end
      @(posedge i_clk);
      #1;
      check("count",     int'(o_count),     mq.size());
      check("full",      int'(o_full),      int'(mq.size() == 8));
      check("empty",     int'(o_empty),     int'(mq.size() == 0));
      check("afull",     int'(o_afull),     int'(mq.size() >= 6));
      check("rvalid",    int'(o_rvalid),    int'(er));
      check("overflow",  int'(o_overflow),  int'(eo));
      check("underflow", int'(o_underflow), int'(eu));
      if (!er) check("rdata_hold", int'(o_rdata), int'(last_rdata));
   endtask

   initial begin
      i_rest = 1'b1; i_wen_ctrl = 1'b0; i_wdata = 8'h00; i_ren = 1'b0;
      last_rdata = 8'h00;

      // Reset held two cycles, then released
      step(1, 0, 8'h00, 0);
      step(1, 0, 8'h00, 0);
      step(0, 0, 8'h00, 0);
      check("reset_count", int'(o_count), 0);
      check("reset_empty", int'(o_empty), 1);
      check("reset_rdata", int'(o_rdata), 0);

      // Fill with 0x11..0x18
      for (int i = 0; i < 8; i++) begin
         step(0, 1, 8'h11 + 8'(i), 0);
         if (i == 4) check("afull_after5", int'(o_afull), 0);
         if (i == 5) check("afull_after6", int'(o_afull), 1);
      end
      check("fill_count", int'(o_count), 8);
      check("fill_full", int'(o_full), 1);

      // Write while full is dropped
      step(0, 1, 8'hAA, 0);
      check("ovf_pulse", int'(o_overflow), 1);
      step(0, 0, 8'h00, 0);
      check("ovf_once", int'(o_overflow), 0);

      // Full with simultaneous write+read: 0x11 out, 0x77 dropped
      step(0, 1, 8'h77, 1);
      check("full_wr_count", int'(o_count), 7);
      check("full_wr_ovf", int'(o_overflow), 1);

      // Drain 0x12..0x18
      for (int i = 0; i < 7; i++) step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 0);
      check("drain_empty", int'(o_empty), 1);

      // Read while empty
      step(0, 0, 8'h00, 1);
      check("udf_pulse", int'(o_underflow), 1);
      check("udf_rdata", int'(o_rdata), 8'h18);

      // Empty with simultaneous write 0x5C + read
      step(0, 1, 8'h5C, 1);
      check("empty_wr_count", int'(o_count), 1);
      check("empty_wr_udf", int'(o_underflow), 1);
      step(0, 0, 8'h00, 1);
      check("read_5c", int'(o_rdata), 8'h5C);

      // Count 3, simultaneous access keeps the level
      for (int i = 0; i < 3; i++) step(0, 1, 8'h21 + 8'(i), 0);
      step(0, 1, 8'h24, 1);
      check("mid_wr_count", int'(o_count), 3);
      check("mid_wr_data", int'(o_rdata), 8'h21);

      // Wrap-around at level 4
      step(0, 1, 8'h25, 0);
      for (int i = 0; i < 20; i++) step(0, 1, 8'h30 + 8'(i), 1);
      check("wrap_count", int'(o_count), 4);

      // Reset at level 5 with both requests active
      step(0, 1, 8'h60, 0);
      check("pre_rst_count", int'(o_count), 5);
      step(1, 1, 8'h99, 1);
      check("rst_mid_count", int'(o_count), 0);
      check("rst_mid_rvalid", int'(o_rvalid), 0);
      step(0, 1, 8'h01, 0);
      step(0, 1, 8'h02, 0);
      step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 0);
      check("post_rst_empty", int'(o_empty), 1);

      repeat (3) @(posedge i_clk);
      check("exp_q_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
